mmio_uart_tx: RTL

Memory-mapped serial transmitter that sits on the core's single-cycle memory bus beside main memory and responds to accesses in the I/O window (address bit 11 set). Stores to its data register are queued in a small FIFO and shifted out on a UART line (8N1). Status and baud-divisor registers are readable by software, so programs can poll instead of relying on the bench monitor for console output.

---
 rtl/mmio_uart_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 serial transmitter with a byte FIFO,
// pollable status and a software baud divisor.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [31:0] BASE         = 32'h800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        irq_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic          hit;
  logic          sel_data;
  logic          sel_stat;
  logic          sel_div;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          busy;
  logic          ovf;
  logic [15:0]   div_q;
  logic [15:0]   div_eff;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [31:0]   cnt_w;
  logic [3:0]    cnt_sat;

  state_t        state_q;
  state_t        state_d;
  logic [15:0]   timer_q;
  logic [15:0]   timer_d;
  logic [15:0]   bdiv_q;
  logic [15:0]   bdiv_d;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          tx_d;
  logic          tick;

  logic          unused;
  assign unused = ^{address[1:0], data_in[31:16]};

  assign hit      = address[31:4] == BASE[31:4];
  assign sel_data = hit && address[3:2] == 2'd0;
  assign sel_stat = hit && address[3:2] == 2'd1;
  assign sel_div  = hit && address[3:2] == 2'd2;

  assign full     = count == FULL_CNT;
  assign empty    = count == '0;
  assign busy     = state_q != IDLE;
  assign push_req = we && sel_data;
  // Fullness is judged before any same-cycle pop.
  assign push     = push_req && !full;
  assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;

  assign cnt_w    = 32'(count);
  assign cnt_sat  = (cnt_w > 32'd15) ? 4'hF : cnt_w[3:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data_in[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf   <= 1'b0;
      div_q <= CLKS_PER_BIT[15:0];
    end else begin
      if (push_req && full) begin
        ovf <= 1'b1;
      end else if (we && sel_stat && data_in[3]) begin
        ovf <= 1'b0;
      end
      if (we && sel_div) begin
        div_q <= data_in[15:0];
      end
    end
  end

  assign tick = timer_q == 16'd1;

  // Each frame keeps its own copy of the divisor in bdiv.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bdiv_d  = bdiv_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rptr];
          timer_d = div_eff;
          bdiv_d  = div_eff;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          timer_d = bdiv_q;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          timer_d = bdiv_q;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= 16'd1;
      bdiv_q    <= 16'd1;
      idx_q     <= 3'd0;
      shift_q   <= 8'd0;
      tx        <= 1'b1;
      irq_empty <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bdiv_q    <= bdiv_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx        <= tx_d;
      irq_empty <= (state_q == IDLE) && empty;
    end
  end

  always_comb begin
    data_out = '0;
    unique case (1'b1)
      sel_stat: data_out = {24'd0, cnt_sat, ovf, busy, empty, full};
      sel_div:  data_out = {16'd0, div_q};
      default:  data_out = '0;
    endcase
  end

endmodule
